// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job arbiter: control words, widths and FSM states.
package mac_pkg;

    localparam int OPND_W = 32;
    localparam int RES_W  = 16;

    localparam logic [7:0] CTRL_IDLE = 8'h80;
    localparam logic [7:0] CTRL_ARM  = 8'h81;
    localparam logic [7:0] CTRL_RUN  = 8'h83;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        RESP
    } mac_state_t;

endpackage

// File: rtl/mac_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr,
// wrapping past NUM_REQ-1 to 0. Returns a one-hot grant and its index.
module mac_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mac_job_arbiter.sv
// Round-robin scheduler sharing one multi-cycle MAC between NUM_REQ requesters.
// Optional RUN watchdog enabled by defining MAC_TIMEOUT_EN.
module mac_job_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int PTR_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OPND_W-1:0] req_ina,
    input  logic [NUM_REQ*OPND_W-1:0] req_inb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [OPND_W-1:0]         MAC_INA,
    output logic [OPND_W-1:0]         MAC_INB,
    output logic [7:0]                MAC_CTRL,
    input  logic [RES_W-1:0]          MAC_OUT,
    input  logic                      IRQ_MAC
);

    mac_state_t         state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic [OPND_W-1:0]  sel_ina, sel_inb;
    logic               tmo_hit;

    mac_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    always_comb begin
        sel_ina = '0;
        sel_inb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_ina = req_ina[i*OPND_W +: OPND_W];
                sel_inb = req_inb[i*OPND_W +: OPND_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        MAC_CTRL  = CTRL_IDLE;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = pick_grant;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                MAC_CTRL  = CTRL_ARM;
                state_nxt = RUN;
            end
            RUN: begin
                MAC_CTRL = CTRL_RUN;
                if (IRQ_MAC || tmo_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            MAC_INA  <= '0;
            MAC_INB  <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req_valid) begin
                MAC_INA <= sel_ina;
                MAC_INB <= sel_inb;
                owner   <= pick_idx;
            end
            // IRQ takes priority over a watchdog expiry in the same cycle.
            if (state == RUN && IRQ_MAC) rsp_data <= MAC_OUT;
            else if (state == RUN && tmo_hit) rsp_data <= '0;
            if (state == RESP) rr_ptr <= PTR_W'((int'(owner) + 1) % NUM_REQ);
        end
    end

`ifdef MAC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counter is zero on the first RUN cycle; expiry lands after TIMEOUT_CYCLES RUN cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == ARM) tmo_cnt <= '0;
            else if (state == RUN) tmo_cnt <= tmo_cnt + 1'b1;
            if (state == RUN && IRQ_MAC) rsp_err <= 1'b0;
            else if (state == RUN && tmo_hit) rsp_err <= 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed scoreboard bench for mac_job_arbiter; the bench plays the MAC unit.
`timescale 1ns/1ps
module tb_mac_job_arbiter;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_ready, rsp_valid;
    logic [NR*32-1:0] req_ina, req_inb;
    logic [15:0]     rsp_data;
    logic            rsp_err, busy;
    logic [31:0]     MAC_INA, MAC_INB;
    logic [7:0]      MAC_CTRL;
    logic [15:0]     MAC_OUT;
    logic            IRQ_MAC;

    logic [31:0] ina_v [NR];
    logic [31:0] inb_v [NR];

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_rsp;

    always #5 clk = ~clk;

    assign req_ina = {ina_v[3], ina_v[2], ina_v[1], ina_v[0]};
    assign req_inb = {inb_v[3], inb_v[2], inb_v[1], inb_v[0]};

    mac_job_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ina   (req_ina),
        .req_inb   (req_inb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .MAC_INA   (MAC_INA),
        .MAC_INB   (MAC_INB),
        .MAC_CTRL  (MAC_CTRL),
        .MAC_OUT   (MAC_OUT),
        .IRQ_MAC   (IRQ_MAC)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int g);
        return NR'(1) << g;
    endfunction

    // Scoreboard consumer: every response pulse must match the oldest expected job.
    always @(posedge clk) begin
        #1;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_owner", 32'(rsp_valid), 32'(onehot(e.idx)));
                chk("sb_data", 32'(rsp_data), 32'(e.data));
                chk("sb_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // One complete job: grant g expected, k RUN cycles before IRQ (or watchdog if tmo).
    task automatic job(input logic [NR-1:0] vmask, input bit hold, input int g, input int k,
                       input logic [15:0] res, input bit irq_early, input bit tmo);
        exp_t e;
        @(negedge clk);
        req_valid = vmask;
        IRQ_MAC   = irq_early;
        #1;
        chk("idle_ready", 32'(req_ready), 32'(onehot(g)));
        chk("idle_ctrl", 32'(MAC_CTRL), 32'h80);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("rsp_hold", 32'(rsp_data), 32'(last_rsp));
        e.idx  = g;
        e.data = tmo ? 16'h0000 : res;
        e.err  = tmo;
        sb.push_back(e);
        last_rsp = e.data;
        @(negedge clk);
        if (!hold) req_valid = '0;
        #1;
        chk("arm_ctrl", 32'(MAC_CTRL), 32'h81);
        chk("arm_ready", 32'(req_ready), 32'(0));
        chk("arm_ina", MAC_INA, ina_v[g]);
        chk("arm_inb", MAC_INB, inb_v[g]);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            IRQ_MAC = 1'b0;
            MAC_OUT = 16'($urandom);
            #1;
            chk("run_ctrl", 32'(MAC_CTRL), 32'h83);
            chk("run_rsp", 32'(rsp_valid), 32'(0));
            chk("run_ina", MAC_INA, ina_v[g]);
            if (i == k - 1 && !tmo) begin
                IRQ_MAC = 1'b1;
                MAC_OUT = res;
            end
        end
        @(negedge clk);
        IRQ_MAC = 1'b0;
        MAC_OUT = ~res;
        #1;
        chk("resp_valid", 32'(rsp_valid), 32'(onehot(g)));
        chk("resp_data", 32'(rsp_data), 32'(e.data));
        chk("resp_err", 32'(rsp_err), 32'(e.err));
        chk("resp_ctrl", 32'(MAC_CTRL), 32'h80);
        chk("resp_busy", 32'(busy), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        IRQ_MAC   = 1'b0;
        MAC_OUT   = '0;
        last_rsp  = '0;
        ina_v[0]  = 32'h56CED903;
        inb_v[0]  = 32'hC3CCD903;
        for (int i = 1; i < NR; i++) begin
            ina_v[i] = $urandom;
            inb_v[i] = $urandom;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", 32'(MAC_CTRL), 32'h80);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp", 32'(rsp_valid), 32'(0));
        chk("rst_data", 32'(rsp_data), 32'(0));
        chk("rst_err", 32'(rsp_err), 32'(0));
        chk("rst_ina", MAC_INA, 32'(0));
        chk("rst_inb", MAC_INB, 32'(0));
        reset = 1'b0;

        job(4'b0001, 1'b0, 0, 3, 16'hBEEF, 1'b0, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_rsp = '0;

        for (int j = 0; j < 8; j++)
            job(4'hF, 1'b1, j % 4, 1 + j % 3, 16'(16'h1111 * j + 7), 1'b0, 1'b0);
        req_valid = '0;

        job(4'b0100, 1'b0, 2, 2, 16'hA5A5, 1'b0, 1'b0);
        job(4'b0100, 1'b0, 2, 1, 16'h5A5A, 1'b0, 1'b0);
        job(4'b1001, 1'b0, 3, 1, 16'h1234, 1'b0, 1'b0);

        job(4'b0001, 1'b0, 0, 4, 16'hC0DE, 1'b1, 1'b0);

        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        chk("rr_ready", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        IRQ_MAC = 1'b1;
        reset   = 1'b1;
        #1;
        chk("midrst_run", 32'(MAC_CTRL), 32'h83);
        @(negedge clk);
        reset   = 1'b0;
        IRQ_MAC = 1'b0;
        #1;
        chk("midrst_rsp", 32'(rsp_valid), 32'(0));
        chk("midrst_ctrl", 32'(MAC_CTRL), 32'h80);
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_ina", MAC_INA, 32'(0));
        chk("midrst_data", 32'(rsp_data), 32'(0));
        last_rsp = '0;

        job(4'b1001, 1'b0, 0, 2, 16'h0F0F, 1'b0, 1'b0);

`ifdef MAC_TIMEOUT_EN
        job(4'b0010, 1'b0, 1, 16, 16'hFFFF, 1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_job_arbiter.md
Name: mac_job_arbiter

Overview:
- Round-robin scheduler that shares one multi-cycle `mac` unit between NUM_REQ requesters.
- Accepts one operand pair per job, drives the MAC control sequence (enable, arm, run) and waits for IRQ_MAC.
- Returns the 16-bit MAC_OUT to the requester that owns the job.
- Sits directly in front of `mac`; requesters never touch MAC_CTRL.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer and granted index.
- TIMEOUT_CYCLES, 64, watchdog limit in RUN (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job request; held until req_ready.
- req_ina  in  NUM_REQ*32  packed operand A; slice i belongs to requester i.
- req_inb  in  NUM_REQ*32  packed operand B.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
- rsp_data  out  16  result; valid only while any rsp_valid bit is high.
- rsp_err  out  1  timeout flag, qualified by rsp_valid (MAC_TIMEOUT_EN only; otherwise tied 0).
- busy  out  1  high in every state except IDLE.
- MAC_INA  out  32  operand A to mac.
- MAC_INB  out  32  operand B to mac.
- MAC_CTRL  out  8  mac control word.
- MAC_OUT  in  16  mac result.
- IRQ_MAC  in  1  mac done; treated as a level.

Behaviour:
- Control encodings: CTRL_IDLE=8'h80 (enabled, idle), CTRL_ARM=8'h81 (load operands), CTRL_RUN=8'h83 (run).
- Reset values: state=IDLE; rr_ptr=0; MAC_CTRL=8'h80; MAC_INA=0; MAC_INB=0; req_ready=0; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0.
- States: IDLE -> ARM -> RUN -> RESP -> IDLE.
- IDLE:
  - If req_valid is nonzero, grant the first set bit scanning from rr_ptr upward with wrap-around.
  - In that same cycle: pulse req_ready[g]; register the operand slices into MAC_INA/MAC_INB; store g; go to ARM.
  - If req_valid is zero, stay in IDLE with MAC_CTRL=8'h80.
- ARM: MAC_CTRL=8'h81 for exactly one cycle; operands are stable; go to RUN.
- RUN:
  - MAC_CTRL=8'h83; MAC_INA/MAC_INB are held.
  - On the first cycle IRQ_MAC is sampled high, capture MAC_OUT into rsp_data and go to RESP.
- RESP:
  - rsp_valid[g]=1 for one cycle; MAC_CTRL=8'h80.
  - rr_ptr <= (g+1) mod NUM_REQ; go to IDLE.
- Latency: accept at cycle t, ARM at t+1, RUN from t+2; IRQ seen at t+2+k gives rsp_valid at t+3+k.
- Back-to-back throughput: the next grant can occur at the earliest in the cycle after RESP.
- IRQ_MAC high in IDLE, ARM or RESP is ignored. A stale-high IRQ does not complete a job early, because IRQ is sampled only in RUN.
- Requesters that deassert req_valid before being granted simply lose the slot. No buffering of unaccepted requests.
- Only one job is ever outstanding.
- A requester may re-request in the same cycle its rsp_valid is high; it is eligible at the next IDLE scan.
- rr_ptr wraps from NUM_REQ-1 to 0.
- With all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Reset mid-job (any state): the job is discarded with no rsp_valid, all outputs return to their reset values at the next edge, and rr_ptr returns to 0.
- rsp_data holds its last value between responses.

Optional Feature:
- Macro: MAC_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES with no IRQ, go to RESP with rsp_data=16'h0000 and rsp_err=1.
  - MAC_CTRL returns to 8'h80 (abort).
  - If IRQ_MAC and the timeout occur in the same cycle, IRQ wins and rsp_err=0.
- Undefined: no counter is built; rsp_err is tied to 0; RUN waits indefinitely.

Decomposition:
- Package mac_pkg holds:
  - localparams CTRL_IDLE, CTRL_ARM, CTRL_RUN;
  - the state enum (IDLE, ARM, RUN, RESP);
  - MAC operand width 32 and result width 16.
- One sub-module: mac_rr_pick. It is a combinational round-robin priority picker with inputs req vector and rr_ptr, and outputs a one-hot grant and its index. It is reusable by other shared-resource arbiters.

Test Plan:
- Single request: requester 0 sends INA=32'h56CED903, INB=32'hC3CCD903. Expect req_ready[0] in the same cycle, MAC_CTRL sequence 80 -> 81 -> 83, and rsp_valid[0] one cycle after IRQ_MAC with rsp_data equal to MAC_OUT.
- All four requesters valid continuously for 8 jobs: grant order 0,1,2,3,0,1,2,3; each rsp_valid matches its grantee.
- Requester 2 only, with rr_ptr=3: grant goes to 2 (wrap-around scan); rr_ptr becomes 3 afterwards.
- reset asserted in RUN: no rsp_valid; next cycle MAC_CTRL=8'h80, busy=0, rr_ptr=0; a new request is then served normally.
- IRQ_MAC held high during IDLE and ARM: no early completion; the response occurs only after IRQ is seen in RUN.
- MAC_TIMEOUT_EN with TIMEOUT_CYCLES=16 and IRQ never asserted: rsp_valid occurs 16 cycles after RUN entry with rsp_err=1 and rsp_data=0.
